// File: rtl/domino_add_sequencer.sv
// rtl/domino_add_sequencer.sv - precharge/evaluate sequencer for the domino add/sub datapath
// Optional signed-overflow output RSP_OVF is enabled by defining SEQ_OVERFLOW_EN.
module domino_add_sequencer #(
    parameter int WIDTH       = 8,
    parameter int EVAL_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic             req_sub,
    output logic [WIDTH-1:0] dp_a,
    output logic [WIDTH-1:0] dp_b,
    output logic             dp_sub,
    output logic             dp_eval,
    input  logic [WIDTH-1:0] dp_sum,
    input  logic             dp_cout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout,
`ifdef SEQ_OVERFLOW_EN
    output logic             rsp_ovf,
`endif
    output logic             busy
);

    localparam int CNT_W = $clog2(EVAL_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EVAL_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        EVAL = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [WIDTH-1:0] dp_a_n, dp_b_n, rsp_sum_n;
    logic             dp_sub_n, dp_eval_n, rsp_valid_n, rsp_cout_n;
    logic             accept;
`ifdef SEQ_OVERFLOW_EN
    logic             rsp_ovf_n;
    logic             ovf_now;
`endif

    assign req_ready = (state == IDLE) || ((state == RESP) && rsp_ready);
    assign busy      = (state != IDLE);
    assign accept    = req_valid && req_ready;

`ifdef SEQ_OVERFLOW_EN
    // Signed overflow from the held operands and the settled sum MSB.
    assign ovf_now = dp_sub ? ((dp_a[WIDTH-1] != dp_b[WIDTH-1]) && (dp_sum[WIDTH-1] != dp_a[WIDTH-1]))
                            : ((dp_a[WIDTH-1] == dp_b[WIDTH-1]) && (dp_sum[WIDTH-1] != dp_a[WIDTH-1]));
`endif

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        dp_a_n      = dp_a;
        dp_b_n      = dp_b;
        dp_sub_n    = dp_sub;
        dp_eval_n   = dp_eval;
        rsp_valid_n = rsp_valid;
        rsp_sum_n   = rsp_sum;
        rsp_cout_n  = rsp_cout;
`ifdef SEQ_OVERFLOW_EN
        rsp_ovf_n   = rsp_ovf;
`endif
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_n = PRE;
                end
            end
            PRE: begin
                state_n   = EVAL;
                cnt_n     = '0;
                dp_eval_n = 1'b1;
            end
            EVAL: begin
                if (cnt == CNT_LAST) begin
                    state_n     = RESP;
                    dp_eval_n   = 1'b0;
                    rsp_valid_n = 1'b1;
                    rsp_sum_n   = dp_sum;
                    rsp_cout_n  = dp_cout;
`ifdef SEQ_OVERFLOW_EN
                    rsp_ovf_n   = ovf_now;
`endif
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_n = 1'b0;
                    state_n     = req_valid ? PRE : IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        // Operands only move on acceptance so the carry chain sees stable inputs.
        if (accept) begin
            dp_a_n   = req_a;
            dp_b_n   = req_b;
            dp_sub_n = req_sub;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            dp_a      <= '0;
            dp_b      <= '0;
            dp_sub    <= 1'b0;
            dp_eval   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
`ifdef SEQ_OVERFLOW_EN
            rsp_ovf   <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            dp_a      <= dp_a_n;
            dp_b      <= dp_b_n;
            dp_sub    <= dp_sub_n;
            dp_eval   <= dp_eval_n;
            rsp_valid <= rsp_valid_n;
            rsp_sum   <= rsp_sum_n;
            rsp_cout  <= rsp_cout_n;
`ifdef SEQ_OVERFLOW_EN
            rsp_ovf   <= rsp_ovf_n;
`endif
        end
    end

endmodule

// File: doc/domino_add_sequencer.md
# domino_add_sequencer

Sequencer for the domino adder/subtractor datapath built from the SPG cells: accepts one operation (A, B, Sub) at a time over a valid/ready request port and drives the shared datapath through precharge and evaluate phases. It holds the operands stable while the carry chain settles, captures sum and carry-out at the end of evaluation, and returns the result over a valid/ready response port. It sits between the issuing control logic and the datapath's A/B/Sub/CLK-gating inputs.

## Interface
- WIDTH, 8: operand and sum width in bits.
- EVAL_CYCLES, 2: number of evaluate cycles before capture. Must be ≥1; the counter is sized to hold EVAL_CYCLES.
- CLK  in  1  single clock; all state updates on the rising edge.
- RST  in  1  reset, synchronous, active-high.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  sequencer can accept a request this cycle.
- REQ_A, REQ_B  in  WIDTH  operands.
- REQ_SUB  in  1  1 = A−B, 0 = A+B.
- DP_A, DP_B  out  WIDTH  registered operands to the datapath.
- DP_SUB  out  1  registered Sub to the datapath.
- DP_EVAL  out  1  domino phase gate to the datapath: 0 = precharge, 1 = evaluate.
- DP_SUM  in  WIDTH  datapath sum; valid only in the final evaluate cycle.
- DP_COUT  in  1  datapath carry-out; for subtract, 1 = no borrow.
- RSP_VALID  out  1  result available.
- RSP_READY  in  1  consumer accepts the result.
- RSP_SUM  out  WIDTH  captured sum.
- RSP_COUT  out  1  captured carry-out.
- BUSY  out  1  1 in any state other than IDLE.

## Operation
- States: IDLE, PRE, EVAL, RESP.
- IDLE:
  - REQ_READY=1.
  - On REQ_VALID, at the edge: latch REQ_A/REQ_B/REQ_SUB into DP_A/DP_B/DP_SUB, then go to PRE.
- PRE: exactly 1 cycle with DP_EVAL=0, then go to EVAL with the counter at 0.
- EVAL:
  - DP_EVAL=1 for EVAL_CYCLES cycles.
  - On the edge that ends the last EVAL cycle, capture DP_SUM/DP_COUT into RSP_SUM/RSP_COUT, set DP_EVAL=0, and go to RESP.
- RESP:
  - RSP_VALID=1. RSP_SUM/RSP_COUT are held stable until the handshake.
  - If RSP_VALID && RSP_READY and there is no request: go to IDLE.
- Back-to-back requests:
  - REQ_READY = (state==IDLE) || (state==RESP && RSP_READY).
  - If the response handshakes and REQ_VALID is high at the same edge, the new operands are latched and the next state is PRE directly.
- DP_A/DP_B/DP_SUB change only on request acceptance. They are constant from PRE through capture.
- Arithmetic is performed by the datapath. The sequencer does no sign extension and no width change; WIDTH bits pass straight through.
- Reset:
  - RST=1 at any edge forces IDLE and clears the counter.
  - All registered outputs go to 0: DP_A, DP_B, DP_SUB, DP_EVAL, RSP_VALID, RSP_SUM, RSP_COUT (and RSP_OVF when configured).
  - An in-flight operation is discarded and no response is produced.
  - REQ_READY=1 and BUSY=0 from the first cycle after RST is released.

## Timing
- Request accepted at edge k. PRE occupies k→k+1; EVAL occupies k+1→k+1+EVAL_CYCLES.
- RSP_VALID rises at edge k+1+EVAL_CYCLES: latency EVAL_CYCLES+1 cycles (3 at the default).
- Minimum issue interval with RSP_READY held high is EVAL_CYCLES+2 cycles (4 at the default).
- REQ_READY and BUSY are combinational from state (and RSP_READY). All other outputs are registered.
- REQ_VALID in PRE/EVAL is ignored; REQ_READY=0 in those states.
- RSP_READY outside RESP is ignored.

## Configuration
- SEQ_OVERFLOW_EN defined:
  - Adds output RSP_OVF (1 bit), the signed overflow registered at capture.
  - Add: (A[msb]==B[msb]) && (S[msb]!=A[msb]).
  - Subtract: (A[msb]!=B[msb]) && (S[msb]!=A[msb]).
  - Held and reset like RSP_SUM.
- SEQ_OVERFLOW_EN undefined: the RSP_OVF port and its logic are absent. All other behaviour is identical.

## Test plan
Bench setup: WIDTH=8, EVAL_CYCLES=2. The datapath model outputs the true result when DP_EVAL=1 and 0 when DP_EVAL=0.

- Reset: RST=1 for 2 cycles with REQ_VALID=1 → all registered outputs 0 and no acceptance during reset. After release: REQ_READY=1, BUSY=0.
- Add: A=0x3C, B=0x05, SUB=0 → DP_EVAL sequence 0,1,1 after acceptance; RSP_VALID at +3 cycles; RSP_SUM=0x41, RSP_COUT=0.
- Subtract with backpressure: A=0x10, B=0x20, SUB=1, RSP_READY=0 for 4 cycles → RSP_SUM=0xF0 and RSP_COUT=0 stay stable and REQ_READY=0 throughout; on the RSP_READY=1 edge → IDLE.
- Back-to-back: 0xFF+0x01 followed by 0x05−0x03 presented during the RESP handshake → first result 0x00/COUT=1; second accepted on the same edge with no IDLE cycle; second result 0x02/COUT=1; issue interval 4 cycles.
- Reset mid-operation: RST=1 in the second EVAL cycle → next cycle state is IDLE with DP_EVAL=0; RSP_VALID never asserts; a following 0x01+0x01 completes normally with result 0x02.
- SEQ_OVERFLOW_EN: 0x7F+0x01 → RSP_SUM=0x80, RSP_OVF=1; 0x80−0x01 → 0x7F, OVF=1; 0x10+0x20 → 0x30, OVF=0.
